// File: rtl/muldiv_pkg.sv
// Shared decode constants and enumerations for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
  typedef enum logic [1:0] {MUL_S, MUL_U, DIV_S, DIV_U} op_e;

  function automatic logic is_muldiv_funct(input logic [5:0] funct);
    return funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

  function automatic logic is_start_funct(input logic [5:0] funct);
    return funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// Iterative datapath: radix-2 shift-add multiply and restoring divide sharing one
// 64-bit accumulator, with the final two's-complement sign correction.
module ex_muldiv_core
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  op_e               op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] hi_res,
  output logic [DATA_W-1:0] lo_res
);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   divisor_q;
  op_e                 op_q;
  logic                neg_q, rneg_q, div0_q;

  logic                is_signed;
  logic [DATA_W-1:0]   rs_mag, rt_mag;

  assign is_signed = (op == MUL_S) || (op == DIV_S);
  assign rs_mag    = (is_signed && rs_data[DATA_W-1]) ? -rs_data : rs_data;
  assign rt_mag    = (is_signed && rt_data[DATA_W-1]) ? -rt_data : rt_data;

  // Multiply: hi half accumulates, multiplier bits drain out of the low half.
  logic [DATA_W:0]     mul_sum;
  // Divide: {rem, quot} shifts left; quotient bits shift in at the bottom.
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W+1:0]   diff;
  logic                is_mul;

  assign is_mul = (op_q == MUL_S) || (op_q == MUL_U);

  always_comb begin
    mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]};
    if (acc_q[0]) mul_sum = mul_sum + {1'b0, divisor_q};
    rem_sh  = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    diff    = {1'b0, rem_sh} - {2'b00, divisor_q};
    if (is_mul) begin
      acc_d = {mul_sum, acc_q[DATA_W-1:1]};
    end else if (diff[DATA_W+1]) begin
      acc_d = {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
    end else begin
      acc_d = {diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      divisor_q <= '0;
      op_q      <= MUL_S;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      div0_q    <= 1'b0;
      count     <= '0;
    end else if (start) begin
      acc_q     <= {{DATA_W{1'b0}}, rs_mag};
      divisor_q <= rt_mag;
      op_q      <= op;
      neg_q     <= is_signed & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
      rneg_q    <= is_signed & rs_data[DATA_W-1];
      div0_q    <= (rt_data == '0);
      count     <= '0;
    end else if (step) begin
      acc_q     <= acc_d;
      count     <= count + CNT_W'(1);
    end
  end

  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quot, rem;

  // With a zero divisor the remainder path ends holding |rs|, so the sign fix
  // restores the original signed rs; only the quotient needs forcing.
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    rem  = rneg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    if (div0_q)     quot = '1;
    else if (neg_q) quot = -acc_q[DATA_W-1:0];
    else            quot = acc_q[DATA_W-1:0];
    hi_res = is_mul ? prod[2*DATA_W-1:DATA_W] : rem;
    lo_res = is_mul ? prod[DATA_W-1:0] : quot;
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: decode, IDLE/RUN/FIX control, HI/LO registers
// and the stall request to the hazard logic.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [31:0]       instr_in,
  input  logic [DATA_W-1:0] rs_data_in,
  input  logic [DATA_W-1:0] rt_data_in,
  input  logic              flush,
  output logic              stall_req,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] mf_data,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  state_e            state;
  logic [5:0]        opcode, funct;
  logic              is_special, accept, start;
  op_e               op;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] hi_res, lo_res;
  logic              unused_instr;

  assign opcode       = instr_in[31:26];
  assign funct        = instr_in[5:0];
  assign unused_instr = ^instr_in[25:6];

  assign is_special = valid_in && (opcode == OP_SPECIAL);
  assign accept     = is_special && !busy && !flush;
  assign start      = accept && is_start_funct(funct);
  assign stall_req  = is_special && busy && is_muldiv_funct(funct);
  assign mf_data    = (funct == F_MFHI) ? hi_out : lo_out;

  always_comb begin
    unique case (funct[1:0])
      2'b00:   op = MUL_S;
      2'b01:   op = MUL_U;
      2'b10:   op = DIV_S;
      default: op = DIV_U;
    endcase
  end

  ex_muldiv_core #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .step    (state == RUN),
    .op      (op),
    .rs_data (rs_data_in),
    .rt_data (rt_data_in),
    .count   (count),
    .hi_res  (hi_res),
    .lo_res  (lo_res)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (count == CNT_W'(DATA_W - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= !flush;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // MT* can only be accepted while idle, so it never collides with the FIX write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (state == FIX && !flush) begin
      hi_out <= hi_res;
      lo_out <= lo_res;
    end else if (accept && funct == F_MTHI) begin
      hi_out <= rs_data_in;
    end else if (accept && funct == F_MTLO) begin
      lo_out <= rs_data_in;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with hand-computed HI/LO results.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] instr_in = '0;
  logic [31:0] rs_data_in = '0;
  logic [31:0] rt_data_in = '0;
  logic        flush = 1'b0;
  logic        stall_req, busy, done;
  logic [31:0] mf_data, hi_out, lo_out;

  int n_vec = 0;
  int n_err = 0;

  ex_muldiv_unit dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .instr_in   (instr_in),
    .rs_data_in (rs_data_in),
    .rt_data_in (rt_data_in),
    .flush      (flush),
    .stall_req  (stall_req),
    .busy       (busy),
    .done       (done),
    .mf_data    (mf_data),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Presents one SPECIAL instruction for a single cycle; returns at the
  // falling edge after the accepting rising edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    valid_in   = 1'b1;
    instr_in   = {OP_SPECIAL, 20'h0, f};
    rs_data_in = rs;
    rt_data_in = rt;
    @(negedge clk);
    valid_in   = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cyc = 0;
    int early_done = 0;
    issue(f, rs, rt);
    while (busy && cyc < 100) begin
      if (done) early_done++;
      cyc++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, cyc, 33);
    check({tag, " early_done"}, early_done, 0);
    check({tag, " done"}, {31'b0, done}, 32'd1);
    check({tag, " hi"}, hi_out, exp_hi);
    check({tag, " lo"}, lo_out, exp_lo);
    @(negedge clk);
    check({tag, " done_clear"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int bad;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst hi", hi_out, 32'h0);
    check("rst lo", lo_out, 32'h0);
    reset = 1'b1;

    // Tests 1-4: arithmetic and boundary cases
    run_op("mult_neg", F_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_neg", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_by0", F_DIVU, 32'h64, 32'h0, 32'h64, 32'hFFFFFFFF);
    run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("div_neg_by0", F_DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF);

    // Test 5: MTLO, then MULT with MFLO held behind it
    issue(F_MTLO, 32'h1234, 32'h0);
    check("mtlo lo", lo_out, 32'h1234);
    check("mtlo busy", {31'b0, busy}, 32'd0);
    check("mtlo done", {31'b0, done}, 32'd0);
    issue(F_MULT, 32'd2, 32'd3);
    valid_in = 1'b1;
    instr_in = {OP_SPECIAL, 20'h0, F_MFLO};
    cyc = 0;
    bad = 0;
    while (busy && cyc < 100) begin
      if (!stall_req) bad++;
      cyc++;
      @(negedge clk);
    end
    check("mflo stall_while_busy", bad, 0);
    check("mflo stall_cycles", cyc, 33);
    check("mflo stall_idle", {31'b0, stall_req}, 32'd0);
    check("mflo mf_data", mf_data, 32'd6);
    instr_in = {OP_SPECIAL, 20'h0, F_MFHI};
    #1;
    check("mfhi mf_data", mf_data, 32'd0);
    @(negedge clk);
    valid_in = 1'b0;

    // Test 6a: flush mid-RUN leaves HI/LO alone and suppresses done
    issue(F_MTHI, 32'hAAAA, 32'h0);
    issue(F_MTLO, 32'h5555, 32'h0);
    issue(F_MULT, 32'd5, 32'd5);
    valid_in = 1'b1;
    instr_in = {6'h23, 26'h0};
    #1;
    check("nonmd stall", {31'b0, stall_req}, 32'd0);
    valid_in = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 32'd0);
    check("flush hi", hi_out, 32'hAAAA);
    check("flush lo", lo_out, 32'h5555);
    bad = 0;
    repeat (40) begin
      if (done) bad++;
      @(negedge clk);
    end
    check("flush no_done", bad, 0);
    check("flush hi_late", hi_out, 32'hAAAA);

    // Flush beats an MTHI presented in the same cycle
    valid_in   = 1'b1;
    instr_in   = {OP_SPECIAL, 20'h0, F_MTHI};
    rs_data_in = 32'hDEAD;
    flush      = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    flush    = 1'b0;
    check("flush_mthi hi", hi_out, 32'hAAAA);

    // Test 6b: asynchronous reset mid-RUN
    issue(F_MULT, 32'd5, 32'd5);
    repeat (5) @(negedge clk);
    check("pre_rst busy", {31'b0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst hi", hi_out, 32'h0);
    check("async_rst lo", lo_out, 32'h0);
    check("async_rst busy", {31'b0, busy}, 32'd0);
    check("async_rst done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide unit with HI/LO registers, placed in EX of the 8-stage superscalar pipe. Consumes the instruction and register operands latched by the ID pipeline register. Executes MULT/MULTU/DIV/DIVU over multiple cycles and services MFHI/MFLO/MTHI/MTLO. Raises a stall request to the hazard logic while busy.

Parameters:
DATA_W, 32, operand/HI/LO width; only 32 is supported.
CNT_W, 5, iteration counter width; must equal log2(DATA_W).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
valid_in  input  1  instr_in/rs_data_in/rt_data_in valid this cycle
instr_in  input  32  instruction from ID pipeline register
rs_data_in  input  32  rs operand
rt_data_in  input  32  rt operand
flush  input  1  kill the in-flight operation
stall_req  output  1  combinational request to stall upstream
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle pulse when HI/LO update from mul/div
mf_data  output  32  HI or LO for MFHI/MFLO (combinational)
hi_out  output  32  current HI
lo_out  output  32  current LO

Behaviour:
- Reset: one clock with asynchronous, active-low reset. reset=0 immediately forces state IDLE, count=0, HI=LO=0, busy=0, done=0. Internal accumulator/remainder/quotient also clear. Reset mid-operation abandons the op.
- Decode applies only when opcode=6'h00 and valid_in=1. Funct codes: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x10 MFHI, 0x12 MFLO, 0x11 MTHI, 0x13 MTLO. Any other instruction is ignored.
- States: IDLE, RUN, FIX.
- IDLE -> RUN when a mul/div is accepted (valid, idle, no flush) at edge N.
  - Latch |rs| and |rt| (magnitude only for signed ops), the op type, and the result signs.
  - Product/quotient sign = rs[31]^rt[31]. Remainder sign = rs[31].
- RUN:
  - 32 iterations, count 0..31.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring, 1 quotient bit per cycle.
  - RUN -> FIX when count==31.
- FIX:
  - Apply two's-complement sign correction and write HI/LO at edge N+33. MUL: HI=product[63:32], LO=product[31:0]. DIV: LO=quotient, HI=remainder.
  - Return to IDLE. done=1 in the cycle after that edge.
- busy=1 in RUN and FIX. New values are visible on hi_out/lo_out from edge N+33.
- Divide by zero (rt==0, signed or unsigned): full latency. HI=rs_data_in as latched (original signed value), LO=32'hFFFFFFFF.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- MTHI/MTLO when idle: write HI/LO at the next edge. They take one cycle and do not assert busy or done.
- MFHI/MFLO when idle: mf_data = HI/LO combinationally in the same cycle.
- stall_req = valid_in & busy & (instruction is any of the eight funct codes above).
  - Non-muldiv instructions never stall.
  - In the FIX cycle stall_req is still 1. The held instruction is serviced in the first IDLE cycle.
- flush:
  - Forces IDLE at the next edge. HI/LO are unchanged, done stays 0.
  - Flush has priority over accept: an instruction presented with flush=1 is ignored, including MT*.
- A mul/div accepted in the same cycle as a done pulse starts normally; done and busy may both be 1.

Decomposition:
- Package muldiv_pkg holds: funct localparams, the SPECIAL opcode constant, the state enum (IDLE/RUN/FIX), and the op-type enum (MUL_S/MUL_U/DIV_S/DIV_U).
- Sub-module ex_muldiv_core holds the iterative datapath (accumulator, shift/subtract, counter, sign fix).
- The top-level ex_muldiv_unit holds the FSM, decode, HI/LO registers and stall logic.

Test Plan:
1. MULT rs=0xFFFFFFFE, rt=3 -> after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFFA; done pulses exactly once.
2. MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; busy high for exactly 33 cycles.
3. DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=100, rt=7 -> LO=14, HI=2.
4. DIVU rs=0x64, rt=0 -> HI=0x00000064, LO=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
5. MTLO 0x1234 then MULT 2*3 with MFLO held behind it:
   - stall_req=1 through FIX.
   - In the first IDLE cycle stall_req=0 and mf_data=6.
6. Flush and reset mid-operation:
   - Preload HI=0xAAAA, LO=0x5555 via MTHI/MTLO. Start MULT 5*5, assert flush at RUN count 10 -> IDLE next edge, HI=0xAAAA, LO=0x5555, done never pulses.
   - Repeat the MULT and pull reset low mid-RUN -> HI=LO=0 and busy=0 immediately, without waiting for a clock edge.
